// File: rtl/alpide_ctrl_rx_if.sv
// Reply word handshake between the DCTRL receiver and the control-bus master.
// The master side produces the word, the slave side accepts it.
interface alpide_ctrl_rx_if;
   logic [7:0]  chipid_o;
   logic [15:0] data_o;
   logic        valid_o;
   logic        ready_i;

   modport master (
      output chipid_o,
      output data_o,
      output valid_o,
      input  ready_i
   );

   modport slave (
      input  chipid_o,
      input  data_o,
      input  valid_o,
      output ready_i
   );
endinterface

// File: rtl/alpide_ctrl_rx.sv
// ALPIDE DCTRL reply receiver: synchronises the pad, samples one bit per MCLK,
// collects chip ID plus two data characters and holds the word until accepted.
module alpide_ctrl_rx #(
   parameter int TURN_TIMEOUT = 64,
   parameter int GAP_TIMEOUT  = 16,
   parameter int SYNC_STAGES  = 2
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            phase_i,
   input  logic            dctrl_i,
   input  logic            arm_i,
   alpide_ctrl_rx_if.master rx,
   output logic            busy_o,
   output logic            timeout_o,
   output logic            frame_err_o
);

   localparam int TMAX = (TURN_TIMEOUT > GAP_TIMEOUT) ? TURN_TIMEOUT : GAP_TIMEOUT;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] TURN_L = TW'(TURN_TIMEOUT);
   localparam logic [TW-1:0] GAP_L  = TW'(GAP_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_STOP,
      S_HOLD
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [2:0]             cnt_q, cnt_d;
   logic [1:0]             k_q, k_d;
   logic [7:0]             sh_q, sh_d;
   logic [7:0]             b0_q, b0_d;
   logic [7:0]             b1_q, b1_d;
   logic [7:0]             chipid_q, chipid_d;
   logic [15:0]            data_q, data_d;
   logic                   timeout_q, timeout_d;
   logic                   frame_err_q, frame_err_d;

   logic          ce;
   logic          sd;
   logic [TW-1:0] timer_inc;
   logic [TW-1:0] limit;

   assign ce = phase_i;
   assign sd = sync_q[SYNC_STAGES-1];

   // Saturating increment; the timeout fires before the top is ever reached.
   assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TW'(1);
   assign limit     = (k_q == 2'd0) ? TURN_L : GAP_L;

   always_comb begin
      state_d     = state_q;
      sync_d      = {sync_q[SYNC_STAGES-2:0], dctrl_i};
      timer_d     = timer_q;
      cnt_d       = cnt_q;
      k_d         = k_q;
      sh_d        = sh_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      chipid_d    = chipid_q;
      data_d      = data_q;
      timeout_d   = 1'b0;
      frame_err_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (arm_i) begin
               state_d = S_WAIT;
               k_d     = 2'd0;
               timer_d = '0;
            end
         end
         S_WAIT: begin
            if (ce) begin
               if (!sd) begin
                  state_d = S_DATA;
                  cnt_d   = 3'd0;
               end else begin
                  timer_d = timer_inc;
                  if (timer_inc >= limit) begin
                     timeout_d = 1'b1;
                     state_d   = S_IDLE;
                  end
               end
            end
         end
         S_DATA: begin
            if (ce) begin
               sh_d  = {sd, sh_q[7:1]};
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (ce) begin
               if (sd) begin
                  if (k_q == 2'd2) begin
                     chipid_d = b0_q;
                     data_d   = {sh_q, b1_q};
                     state_d  = S_HOLD;
                  end else begin
                     if (k_q == 2'd0) b0_d = sh_q;
                     else             b1_d = sh_q;
                     k_d     = k_q + 2'd1;
                     timer_d = '0;
                     state_d = S_WAIT;
                  end
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_IDLE;
               end
            end
         end
         S_HOLD: begin
            if (rx.ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         sync_q      <= '1;
         timer_q     <= '0;
         cnt_q       <= '0;
         k_q         <= '0;
         sh_q        <= '0;
         b0_q        <= '0;
         b1_q        <= '0;
         chipid_q    <= '0;
         data_q      <= '0;
         timeout_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         timer_q     <= timer_d;
         cnt_q       <= cnt_d;
         k_q         <= k_d;
         sh_q        <= sh_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         chipid_q    <= chipid_d;
         data_q      <= data_d;
         timeout_q   <= timeout_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx.chipid_o = chipid_q;
   assign rx.data_o   = data_q;
   assign rx.valid_o  = (state_q == S_HOLD);
   assign busy_o      = (state_q != S_IDLE);
   assign timeout_o   = timeout_q;
   assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_alpide_ctrl_rx.sv
// Directed bench for the DCTRL reply receiver: one task per scenario,
// DCTRL bits driven one per MCLK period with hand-computed expectations.
module tb_alpide_ctrl_rx;

   logic clk;
   logic rst_n_i;
   logic phase_i;
   logic dctrl_i;
   logic arm_i;
   logic busy_o;
   logic timeout_o;
   logic frame_err_o;

   int errs   = 0;
   int checks = 0;
   int to_cnt = 0;
   int fe_cnt = 0;

   alpide_ctrl_rx_if rx ();

   alpide_ctrl_rx dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n_i),
      .phase_i     (phase_i),
      .dctrl_i     (dctrl_i),
      .arm_i       (arm_i),
      .rx          (rx),
      .busy_o      (busy_o),
      .timeout_o   (timeout_o),
      .frame_err_o (frame_err_o)
   );

   // clk is 2x MCLK; phase toggles on every falling edge
   initial begin
      clk     = 1'b0;
      phase_i = 1'b0;
      forever begin
         #5 clk = 1'b1;
         #5 clk = 1'b0;
         phase_i = ~phase_i;
      end
   end

   always @(negedge clk) begin
      if (timeout_o === 1'b1)   to_cnt++;
      if (frame_err_o === 1'b1) fe_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // One MCLK bit: set just after a falling edge whose next rising edge is not a ce
   task automatic send_bit(input logic b, input logic a = 1'b0);
      do begin
         @(negedge clk);
         #1;
         arm_i = 1'b0;
      end while (phase_i !== 1'b0);
      dctrl_i = b;
      arm_i   = a;
   endtask

   task automatic send_idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b1);
   endtask

   task automatic send_char(input logic [7:0] b, input logic stop,
                            input int arm_at = -1);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i], (i == arm_at));
      send_bit(stop);
   endtask

   task automatic arm();
      do begin
         @(negedge clk);
         #1;
      end while (phase_i !== 1'b0);
      arm_i = 1'b1;
      @(negedge clk);
      #1;
      arm_i = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (rx.valid_o === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({rx.valid_o, busy_o, timeout_o, frame_err_o} !== 4'b0000) begin
         errs++;
         $display("FAIL rst_flags: got %b want 0000",
                  {rx.valid_o, busy_o, timeout_o, frame_err_o});
      end
      checks++;
      if ({rx.chipid_o, rx.data_o} !== 24'h0) begin
         errs++;
         $display("FAIL rst_word: got %h want 000000", {rx.chipid_o, rx.data_o});
      end
      @(negedge clk);
      rst_n_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({rx.valid_o, busy_o} !== 2'b00) begin
         errs++;
         $display("FAIL rst_release: got %b want 00", {rx.valid_o, busy_o});
      end
   endtask

   task automatic test_single();
      int rise;
      arm();
      send_idle(3);
      send_char(8'h12, 1'b1);
      send_char(8'h34, 1'b1);
      send_char(8'hAB, 1'b1);
      rise = -1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (rx.valid_o === 1'b1 && rise < 0) rise = i;
      end
      checks++;
      if (rise !== 3) begin
         errs++;
         $display("FAIL t1_latency: got edge %0d want edge 3", rise);
      end
      checks++;
      if (rx.chipid_o !== 8'h12) begin
         errs++;
         $display("FAIL t1_chipid: got %h want 12", rx.chipid_o);
      end
      checks++;
      if (rx.data_o !== 16'hAB34) begin
         errs++;
         $display("FAIL t1_data: got %h want ab34", rx.data_o);
      end
      checks++;
      if (busy_o !== 1'b1) begin
         errs++;
         $display("FAIL t1_busy_hold: got %b want 1", busy_o);
      end
      @(negedge clk);
      rx.ready_i = 1'b1;
      @(posedge clk);
      #1;
      rx.ready_i = 1'b0;
      checks++;
      if ({rx.valid_o, busy_o} !== 2'b00) begin
         errs++;
         $display("FAIL t1_accept: got %b want 00", {rx.valid_o, busy_o});
      end
   endtask

   task automatic test_hold();
      bit ok;
      int bad;
      arm();
      send_idle(3);
      send_char(8'h12, 1'b1);
      send_char(8'h34, 1'b1);
      send_char(8'hAB, 1'b1);
      wait_valid(ok);
      checks++;
      if (!ok) begin
         errs++;
         $display("FAIL t2_valid: got no valid want valid");
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (rx.valid_o !== 1'b1 || rx.data_o !== 16'hAB34 ||
             rx.chipid_o !== 8'h12) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errs++;
         $display("FAIL t2_hold: got %0d unstable cycles want 0", bad);
      end
      @(negedge clk);
      rx.ready_i = 1'b1;
      @(posedge clk);
      #1;
      rx.ready_i = 1'b0;
      checks++;
      if (rx.valid_o !== 1'b0) begin
         errs++;
         $display("FAIL t2_drop: got %b want 0", rx.valid_o);
      end
   endtask

   task automatic test_turn_timeout();
      int first;
      int pulses;
      int vhigh;
      do begin
         @(negedge clk);
         #1;
      end while (phase_i !== 1'b0);
      arm_i  = 1'b1;
      first  = -1;
      pulses = 0;
      vhigh  = 0;
      for (int i = 0; i < 140; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) arm_i = 1'b0;
         if (timeout_o === 1'b1) begin
            pulses++;
            if (first < 0) first = i;
         end
         if (rx.valid_o !== 1'b0) vhigh++;
      end
      checks++;
      if (first !== 127) begin
         errs++;
         $display("FAIL t3_when: got edge %0d want edge 127 (64th ce)", first);
      end
      checks++;
      if (pulses !== 1) begin
         errs++;
         $display("FAIL t3_pulses: got %0d want 1", pulses);
      end
      checks++;
      if (vhigh !== 0 || busy_o !== 1'b0) begin
         errs++;
         $display("FAIL t3_idle: got valid_cycles=%0d busy=%b want 0 0", vhigh, busy_o);
      end
      checks++;
      if ({rx.chipid_o, rx.data_o} !== 24'h12AB34) begin
         errs++;
         $display("FAIL t3_keep: got %h want 12ab34", {rx.chipid_o, rx.data_o});
      end
   endtask

   task automatic test_frame_err();
      int fe0;
      bit ok;
      fe0 = fe_cnt;
      arm();
      send_idle(2);
      send_char(8'h55, 1'b1);
      send_char(8'h66, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (fe_cnt !== fe0 + 1) begin
         errs++;
         $display("FAIL t4_ferr: got %0d pulses want 1", fe_cnt - fe0);
      end
      checks++;
      if ({busy_o, rx.valid_o} !== 2'b00 || rx.chipid_o !== 8'h12) begin
         errs++;
         $display("FAIL t4_idle: got busy=%b valid=%b chip=%h want 0 0 12",
                  busy_o, rx.valid_o, rx.chipid_o);
      end
      send_idle(3);
      arm();
      send_idle(2);
      send_char(8'h21, 1'b1);
      send_char(8'h43, 1'b1);
      send_char(8'h65, 1'b1);
      wait_valid(ok);
      checks++;
      if (!ok || rx.chipid_o !== 8'h21 || rx.data_o !== 16'h6543) begin
         errs++;
         $display("FAIL t4_retry: got ok=%b chip=%h data=%h want 1 21 6543",
                  ok, rx.chipid_o, rx.data_o);
      end
      @(negedge clk);
      rx.ready_i = 1'b1;
      @(posedge clk);
      #1;
      rx.ready_i = 1'b0;
   endtask

   task automatic test_gap();
      int to0;
      bit ok;
      to0 = to_cnt;
      arm();
      send_idle(2);
      send_char(8'h11, 1'b1);
      send_idle(15);
      send_char(8'h22, 1'b1);
      send_idle(15);
      send_char(8'h33, 1'b1);
      wait_valid(ok);
      checks++;
      if (!ok || rx.chipid_o !== 8'h11 || rx.data_o !== 16'h3322) begin
         errs++;
         $display("FAIL t5_gap15: got ok=%b chip=%h data=%h want 1 11 3322",
                  ok, rx.chipid_o, rx.data_o);
      end
      checks++;
      if (to_cnt !== to0) begin
         errs++;
         $display("FAIL t5_no_to: got %0d timeouts want 0", to_cnt - to0);
      end
      @(negedge clk);
      rx.ready_i = 1'b1;
      @(posedge clk);
      #1;
      rx.ready_i = 1'b0;
      arm();
      send_idle(2);
      send_char(8'h44, 1'b1);
      send_idle(16);
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (to_cnt !== to0 + 1 || busy_o !== 1'b0) begin
         errs++;
         $display("FAIL t5_gap16: got timeouts=%0d busy=%b want 1 0",
                  to_cnt - to0, busy_o);
      end
      send_char(8'h99, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({busy_o, rx.valid_o} !== 2'b00 || rx.data_o !== 16'h3322) begin
         errs++;
         $display("FAIL t5_after: got busy=%b valid=%b data=%h want 0 0 3322",
                  busy_o, rx.valid_o, rx.data_o);
      end
   endtask

   task automatic test_reset_mid();
      int to0;
      int fe0;
      bit ok;
      arm();
      send_idle(2);
      send_char(8'h77, 1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      to0 = to_cnt;
      fe0 = fe_cnt;
      @(negedge clk);
      #2;
      rst_n_i = 1'b0;
      #1;
      checks++;
      if ({rx.valid_o, busy_o, timeout_o, frame_err_o} !== 4'b0000 ||
          {rx.chipid_o, rx.data_o} !== 24'h0) begin
         errs++;
         $display("FAIL t6_async: got flags=%b word=%h want 0000 000000",
                  {rx.valid_o, busy_o, timeout_o, frame_err_o},
                  {rx.chipid_o, rx.data_o});
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n_i = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (to_cnt !== to0 || fe_cnt !== fe0) begin
         errs++;
         $display("FAIL t6_no_pulse: got to=%0d fe=%0d want 0 0",
                  to_cnt - to0, fe_cnt - fe0);
      end
      arm();
      send_idle(2);
      send_char(8'h0F, 1'b1);
      send_bit(1'b1, 1'b1);
      send_bit(1'b1);
      send_char(8'hA5, 1'b1, 3);
      send_char(8'h5A, 1'b1);
      wait_valid(ok);
      checks++;
      if (!ok || rx.chipid_o !== 8'h0F || rx.data_o !== 16'h5AA5) begin
         errs++;
         $display("FAIL t6_arm_ignored: got ok=%b chip=%h data=%h want 1 0f 5aa5",
                  ok, rx.chipid_o, rx.data_o);
      end
      @(negedge clk);
      rx.ready_i = 1'b1;
      @(posedge clk);
      #1;
      rx.ready_i = 1'b0;
      checks++;
      if ({rx.valid_o, busy_o} !== 2'b00) begin
         errs++;
         $display("FAIL t6_end: got %b want 00", {rx.valid_o, busy_o});
      end
   endtask

   initial begin
      rst_n_i    = 1'b0;
      dctrl_i    = 1'b1;
      arm_i      = 1'b0;
      rx.ready_i = 1'b0;
      test_reset();
      test_single();
      test_hold();
      test_turn_timeout();
      test_frame_err();
      test_gap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
